// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer: multi-voice sample player mixing shifted voices into one saturated mono sample
module audio_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_tick_i,
  input  logic [NUM_VOICES-1:0] play_i,
  input  logic [NUM_VOICES-1:0] stop_i,
  input  logic [NUM_VOICES-1:0] voice_loop_i,
  input  logic [2*NUM_VOICES-1:0] voice_vol_i,
  input  logic [ADDR_W*NUM_VOICES-1:0] voice_base_i,
  input  logic [ADDR_W*NUM_VOICES-1:0] voice_len_i,
  output logic mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] sample_out_o,
  output logic sample_valid_o,
  output logic [NUM_VOICES-1:0] voice_active_o,
  output logic [NUM_VOICES-1:0] voice_done_o,
  output logic overrun_o
);
  localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int AW = DATA_W + 3;
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, ACCUM, OUT} state_t;
  state_t state_q;
  logic [VW-1:0] v_q, v_d;
  logic signed [AW-1:0] acc_q, acc_d, ext, shifted;
  logic [NUM_VOICES-1:0] play_pend_q, stop_pend_q, active_q, done_q;
  logic [ADDR_W-1:0] ptr_q [NUM_VOICES];
  logic mem_rd_q, sample_valid_q, overrun_q, frame_start;
  logic [ADDR_W-1:0] mem_addr_q, addr_nx, addr0;
  logic [DATA_W-1:0] sample_out_q, sat;
  logic [ADDR_W-1:0] base [NUM_VOICES];
  logic [ADDR_W-1:0] len [NUM_VOICES];
  logic [1:0] vol [NUM_VOICES];
  logic [NUM_VOICES-1:0] req_play, req_stop, restart, start_act, wrap, adv_act, adv_done;
  logic [ADDR_W-1:0] start_ptr [NUM_VOICES];
  logic [ADDR_W-1:0] adv_ptr [NUM_VOICES];
  assign mem_rd_o = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign sample_out_o = sample_out_q;
  assign sample_valid_o = sample_valid_q;
  assign voice_active_o = active_q;
  assign voice_done_o = done_q;
  assign overrun_o = overrun_q;
  // Frame-start request resolution, end-of-frame pointer advance, mixing and saturation
  always_comb begin
    req_play = play_pend_q | play_i;
    req_stop = stop_pend_q | stop_i;
    frame_start = state_q == IDLE && sample_tick_i;
    for (int i = 0; i < NUM_VOICES; i++) begin
      base[i] = voice_base_i[i*ADDR_W +: ADDR_W];
      len[i] = voice_len_i[i*ADDR_W +: ADDR_W];
      vol[i] = voice_vol_i[2*i +: 2];
      restart[i] = req_play[i] && len[i] != '0 && !req_stop[i];
      start_act[i] = !req_stop[i] && (active_q[i] || restart[i]);
      start_ptr[i] = (restart[i] || req_stop[i]) ? '0 : ptr_q[i];
      wrap[i] = ({1'b0, ptr_q[i]} + 1'b1) >= {1'b0, len[i]};
      adv_act[i] = active_q[i] && (!wrap[i] || voice_loop_i[i]);
      adv_done[i] = active_q[i] && wrap[i] && !voice_loop_i[i];
      adv_ptr[i] = !active_q[i] ? ptr_q[i] : wrap[i] ? '0 : ptr_q[i] + 1'b1;
    end
    v_d = v_q + 1'b1;
    addr0 = base[0] + start_ptr[0];
    addr_nx = base[v_d] + ptr_q[v_d];
    ext = $signed({{3{mem_data_i[DATA_W-1]}}, mem_data_i});
    shifted = ext >>> vol[v_q];
    acc_d = active_q[v_q] ? acc_q + shifted : acc_q;
    sat = acc_q > SMAX ? SMAX[DATA_W-1:0] : acc_q < SMIN ? SMIN[DATA_W-1:0] : acc_q[DATA_W-1:0];
  end
  // Frame sequencer: one read slot and one accumulate slot per voice, then output and advance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      v_q <= '0;
      acc_q <= '0;
      play_pend_q <= '0;
      stop_pend_q <= '0;
      active_q <= '0;
      done_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) ptr_q[i] <= '0;
      mem_rd_q <= 1'b0;
      mem_addr_q <= '0;
      sample_out_q <= '0;
      sample_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      done_q <= '0;
      overrun_q <= overrun_q || (sample_tick_i && state_q != IDLE);
      play_pend_q <= frame_start ? '0 : req_play;
      stop_pend_q <= frame_start ? '0 : req_stop;
      case (state_q)
        IDLE: if (sample_tick_i) begin
          active_q <= start_act;
          ptr_q <= start_ptr;
          acc_q <= '0;
          v_q <= '0;
          mem_rd_q <= start_act[0];
          if (start_act[0]) mem_addr_q <= addr0;
          state_q <= ISSUE;
        end
        ISSUE: begin
          mem_rd_q <= 1'b0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (v_q == LAST) state_q <= OUT;
          else begin
            v_q <= v_d;
            mem_rd_q <= active_q[v_d];
            if (active_q[v_d]) mem_addr_q <= addr_nx;
            state_q <= ISSUE;
          end
        end
        default: begin
          sample_out_q <= sat;
          sample_valid_q <= 1'b1;
          active_q <= adv_act;
          done_q <= adv_done;
          ptr_q <= adv_ptr;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_audio_voice_mixer.sv
// tb_audio_voice_mixer: frame-level reference model plus directed literal checks and random traffic
module tb_audio_voice_mixer;
  localparam int N = 4;
  localparam int AW = 17;
  localparam int DW = 16;
  logic clk = 0, rst = 1, tick = 0;
  logic [N-1:0] play = 0, stop = 0, loop = 0;
  logic [2*N-1:0] vol = 0;
  logic [AW*N-1:0] base = 0, len = 0;
  logic mem_rd, sample_valid, overrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = 0, sample_out;
  logic [N-1:0] active, done;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  audio_voice_mixer #(.NUM_VOICES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .play_i(play), .stop_i(stop),
    .voice_loop_i(loop), .voice_vol_i(vol), .voice_base_i(base), .voice_len_i(len),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .sample_out_o(sample_out), .sample_valid_o(sample_valid),
    .voice_active_o(active), .voice_done_o(done), .overrun_o(overrun)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [AW-1:0] fb(int i); return base[i*AW +: AW]; endfunction
  function automatic logic [AW-1:0] fl(int i); return len[i*AW +: AW]; endfunction
  function automatic logic [1:0] fv(int i); return vol[2*i +: 2]; endfunction
  function automatic logic [DW-1:0] satf(int s);
    return s > 32767 ? 16'h7fff : s < -32768 ? 16'h8000 : DW'(s);
  endfunction

  bit m_busy;
  int m_cnt, m_sum;
  logic [N-1:0] m_act, m_pp, m_ps, m_rp, m_rs, e_done;
  logic [AW-1:0] m_ptr [N];
  logic [AW-1:0] m_a, e_addr;
  logic signed [DW-1:0] m_w;
  logic [DW-1:0] e_out;
  logic e_valid, e_rd, e_over;

  task issue(input int j);
    e_rd = m_act[j];
    if (m_act[j]) e_addr = fb(j) + m_ptr[j];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_sum = 0; m_act = '0; m_pp = '0; m_ps = '0; e_done = '0;
      e_out = '0; e_valid = 0; e_rd = 0; e_over = 0; e_addr = '0;
      for (int i = 0; i < N; i++) m_ptr[i] = '0;
    end else begin
      e_valid = 0; e_done = '0; e_rd = 0;
      if (m_busy) begin
        if (tick) e_over = 1;
        m_pp |= play; m_ps |= stop;
        m_cnt++;
        if (m_cnt % 2 == 0 && m_cnt < 2*N) issue(m_cnt / 2);
        if (m_cnt == 2*N + 1) begin
          e_valid = 1;
          e_out = satf(m_sum);
          for (int i = 0; i < N; i++)
            if (m_act[i]) begin
              if (int'(m_ptr[i]) + 1 < int'(fl(i))) m_ptr[i] = m_ptr[i] + 1;
              else if (loop[i]) m_ptr[i] = '0;
              else begin m_act[i] = 0; m_ptr[i] = '0; e_done[i] = 1; end
            end
          m_busy = 0;
        end
      end else if (tick) begin
        m_rp = m_pp | play; m_rs = m_ps | stop; m_pp = '0; m_ps = '0;
        for (int i = 0; i < N; i++)
          if (m_rs[i]) begin m_act[i] = 0; m_ptr[i] = '0; end
          else if (m_rp[i] && fl(i) != 0) begin m_act[i] = 1; m_ptr[i] = '0; end
        m_sum = 0;
        for (int i = 0; i < N; i++)
          if (m_act[i]) begin
            m_a = fb(i) + m_ptr[i];
            m_w = mem[m_a];
            m_sum += int'(m_w) >>> fv(i);
          end
        m_busy = 1; m_cnt = 0;
        issue(0);
      end else begin
        m_pp |= play; m_ps |= stop;
      end
    end
  end

  always @(negedge clk) begin
    chk("sample_out", sample_out, e_out);
    chk("sample_valid", sample_valid, e_valid);
    chk("voice_active", active, m_act);
    chk("voice_done", done, e_done);
    chk("overrun", overrun, e_over);
    chk("mem_rd", mem_rd, e_rd);
    chk("mem_addr", mem_addr, e_addr);
  end

  task step; @(posedge clk); #1; endtask
  task pulse_play(input logic [N-1:0] p); play = p; step; play = 0; endtask
  task pulse_stop(input logic [N-1:0] p); stop = p; step; stop = 0; endtask
  task setv(input int i, input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [1:0] v);
    base[i*AW +: AW] = b; len[i*AW +: AW] = l; vol[2*i +: 2] = v;
  endtask

  task automatic tick_frame(output logic [DW-1:0] s, output logic [N-1:0] d, output logic [N-1:0] a, output int lat);
    bit got = 0;
    s = '0; d = '0; a = '0; lat = -1;
    tick = 1; step; tick = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (sample_valid) begin got = 1; s = sample_out; d = done; a = active; lat = c; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: no sample_valid within 30 cycles at %0t", $time);
    end
    step;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin @(negedge clk); if (sample_valid) n++; end
    step;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] s;
    logic [N-1:0] d, a;
    int lat, nv;
    logic [DW-1:0] loop_exp [5];
    loop_exp[0] = 16'h0100; loop_exp[1] = 16'h0200; loop_exp[2] = 16'h0100;
    loop_exp[3] = 16'h0200; loop_exp[4] = 16'h0100;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_active", active, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mem_rd", mem_rd, 0);
    step;
    mem[17'h100] = 16'h0010; mem[17'h101] = 16'h0020; mem[17'h102] = 16'h0030;
    setv(0, 17'h100, 3, 0);
    pulse_play(4'b0001);
    tick_frame(s, d, a, lat);
    chk("sv_s0", s, 16'h0010); chk("sv_latency", lat, 9); chk("sv_active", a[0], 1);
    tick_frame(s, d, a, lat);
    chk("sv_s1", s, 16'h0020); chk("sv_done1", d, 0);
    tick_frame(s, d, a, lat);
    chk("sv_s2", s, 16'h0030); chk("sv_done2", d, 4'b0001); chk("sv_inactive", a[0], 0);
    tick_frame(s, d, a, lat);
    chk("sv_s3", s, 16'h0000);
    for (int i = 0; i < N; i++) begin setv(i, 17'h200 + i, 1, 0); mem[17'h200 + i] = 16'h7000; end
    pulse_play(4'hF);
    tick_frame(s, d, a, lat);
    chk("sat_pos", s, 16'h7fff); chk("sat_done", d, 4'hF);
    for (int i = 0; i < N; i++) mem[17'h200 + i] = 16'h9000;
    pulse_play(4'hF);
    tick_frame(s, d, a, lat);
    chk("sat_neg", s, 16'h8000);
    for (int i = 0; i < N; i++) begin setv(i, 17'h200 + i, 1, 2); mem[17'h200 + i] = 16'h7000; end
    pulse_play(4'hF);
    tick_frame(s, d, a, lat);
    chk("sat_vol2", s, 16'h7000);
    for (int i = 0; i < N; i++) setv(i, 0, 0, 0);
    setv(2, 17'h300, 2, 0);
    mem[17'h300] = 16'h0100; mem[17'h301] = 16'h0200;
    loop = 4'b0100;
    pulse_play(4'b0100);
    for (int k = 0; k < 5; k++) begin
      tick_frame(s, d, a, lat);
      chk("loop_s", s, loop_exp[k]); chk("loop_active", a[2], 1); chk("loop_nodone", d, 0);
    end
    pulse_stop(4'b0100);
    tick_frame(s, d, a, lat);
    chk("loop_stopped", a[2], 0);
    loop = 0;
    setv(1, 17'h400, 10, 0);
    for (int i = 0; i < 10; i++) mem[17'h400 + i] = 16'(i * 17 + 1);
    pulse_play(4'b0010);
    for (int k = 0; k < 5; k++) tick_frame(s, d, a, lat);
    chk("sp_ptr4", s, 16'h0045);
    pulse_play(4'b0010);
    tick_frame(s, d, a, lat);
    chk("sp_restart", s, 16'h0001);
    play = 4'b0010; stop = 4'b0010; step; play = 0; stop = 0;
    tick_frame(s, d, a, lat);
    chk("sp_stopwins", a[1], 0); chk("sp_silent", s, 0);
    @(negedge clk);
    chk("ovr_before", overrun, 0);
    step;
    tick = 1; step; tick = 0; step; step; tick = 1; step; tick = 0;
    count_valid(15, nv);
    chk("ovr_one_valid", nv, 1);
    chk("ovr_sticky", overrun, 1);
    pulse_play(4'b0010);
    tick_frame(s, d, a, lat);
    chk("rm_pre", s, 16'h0001);
    tick = 1; step; tick = 0;
    repeat (5) step;
    rst = 1;
    @(negedge clk);
    chk("rm_sample_out", sample_out, 0); chk("rm_active", active, 0);
    chk("rm_mem_addr", mem_addr, 0); chk("rm_overrun", overrun, 0);
    step; rst = 0;
    count_valid(12, nv);
    chk("rm_no_valid", nv, 0);
    tick_frame(s, d, a, lat);
    chk("rm_silent", s, 0); chk("rm_inactive", a, 0);
    for (int r = 0; r < 4; r++) begin
      repeat (12) step;
      pulse_stop(4'hF);
      tick_frame(s, d, a, lat);
      for (int i = 0; i < N; i++)
        setv(i, r == 1 ? 17'((1 << AW) - 2 - i) : 17'($urandom), 17'($urandom_range(0, 6)), 2'($urandom));
      for (int c = 0; c < 400; c++) begin
        tick = $urandom_range(0, 4) == 0;
        play = $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'h0;
        stop = $urandom_range(0, 15) == 0 ? 4'($urandom) : 4'h0;
        if ($urandom_range(0, 31) == 0) loop = 4'($urandom);
        step;
      end
      tick = 0; play = 0; stop = 0;
    end
    repeat (15) step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
